add_share_arb: RTL and testbench

- Time-multiplexes one shared 12-bit combinational adder (13-bit sum) among NREQ requesters.
- Round-robin arbitration with valid/ready request channels and one tagged, back-pressurable response channel.
- Registers the operands into the adder and registers its sum, so the adder sits between two flop stages.
- Sits between client engines (accumulators, address generators) and the single adder instance.

---
 rtl/add_share_arb_pkg.sv | 30 +++
 rtl/add_share_arb_if.sv | 32 +++
 rtl/add_share_arb_rr_pick.sv | 37 +++
 rtl/add_share_arb.sv | 135 +++++++++++++
 tb/tb_add_share_arb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// add_share_arb_pkg : state encoding, adder widths, adder-input packing
// rev 1.0
// ------------------------------------------------------------------------
package add_share_arb_pkg;

    localparam int ADD_W     = 12;
    localparam int ADD_SUM_W = 13;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // The shared adder expects its operands bit-interleaved: a in even lanes, b in odd lanes.
    function automatic logic [2*ADD_W-1:0] pack_add_in(input logic [ADD_W-1:0] a,
                                                       input logic [ADD_W-1:0] b);
        logic [2*ADD_W-1:0] r;
        r = '0;
        for (int k = 0; k < ADD_W; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_share_arb_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// add_share_arb_if : request channels and tagged response channel
// rev 1.0
// ------------------------------------------------------------------------
interface add_share_arb_if
    import add_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface
`default_nettype wire

// File: rtl/add_share_arb_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search starts at ptr
// rev 1.0
// ------------------------------------------------------------------------
module rr_pick
    import add_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    output logic      [NREQ-1:0] grant,
    output logic      [IDW-1:0]  grant_idx,
    output logic                 grant_any
);
    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + 32'(k)) % NREQ);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/add_share_arb.sv
`default_nettype none
// ------------------------------------------------------------------------
// add_share_arb : round-robin time-sharing of one external 12-bit adder
// rev 1.0
// ------------------------------------------------------------------------
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    add_share_arb_if.slave    bus,
    output logic [2*W-1:0]    add_in,
    input  wire logic [W:0]   add_sum,
    output logic [CNTW-1:0]   op_count
);
    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W:0]      rsp_sum_q, rsp_sum_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            accept_en;
    logic            accept;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A new operation may start from IDLE, or in the same cycle the pending result is taken.
    always_comb begin
        accept_en = rst_n && ((state_q == ST_IDLE) ||
                              ((state_q == ST_RESP) && bus.rsp_ready));
        accept    = accept_en && grant_any;
        sel_a     = bus.req_a[grant_idx*W +: W];
        sel_b     = bus.req_b[grant_idx*W +: W];
    end

    assign bus.req_ready = accept_en ? grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign op_count      = op_count_q;
    assign add_in        = (2*W)'(pack_add_in(ADD_W'(a_q), ADD_W'(b_q)));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_sum_d   = add_sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (op_count_q != {CNTW{1'b1}}) begin
                        op_count_d = op_count_q + CNTW'(1);
                    end
                    state_d = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d   = sel_a;
            b_d   = sel_b;
            id_d  = grant_idx;
            ptr_d = IDW'((32'(grant_idx) + 32'd1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            op_count_q  <= op_count_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_add_share_arb : directed + random checks against a transaction model
// rev 1.0
// ------------------------------------------------------------------------
module tb_add_share_arb;
    import add_share_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 12;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NREQ-1:0]   req_valid_r;
    logic [W-1:0]      a_r [NREQ];
    logic [W-1:0]      b_r [NREQ];
    logic              rsp_ready_r;
    logic [NREQ*W-1:0] a_pk, b_pk;

    logic [2*W-1:0] add_in, add_in_s;
    logic [W:0]     add_sum, add_sum_s;
    logic [15:0]    op_count;
    logic [3:0]     op_count_s;

    add_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus   ();
    add_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus_s ();

    always_comb begin
        a_pk = '0;
        b_pk = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_pk[i*W +: W] = a_r[i];
            b_pk[i*W +: W] = b_r[i];
        end
    end

    assign bus.req_valid   = req_valid_r;
    assign bus.req_a       = a_pk;
    assign bus.req_b       = b_pk;
    assign bus.rsp_ready   = rsp_ready_r;
    assign bus_s.req_valid = req_valid_r;
    assign bus_s.req_a     = a_pk;
    assign bus_s.req_b     = b_pk;
    assign bus_s.rsp_ready = rsp_ready_r;

    // External shared adder: undo the interleave and add.
    function automatic logic [W:0] ext_add(input logic [2*W-1:0] x);
        logic [W-1:0] a, b;
        for (int k = 0; k < W; k++) begin
            a[k] = x[2*k];
            b[k] = x[2*k+1];
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign add_sum   = ext_add(add_in);
    assign add_sum_s = ext_add(add_in_s);

    add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_in   (add_in),
        .add_sum  (add_sum),
        .op_count (op_count)
    );

    add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(4)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_s),
        .add_in   (add_in_s),
        .add_sum  (add_sum_s),
        .op_count (op_count_s)
    );

    typedef struct {
        int id;
        int sum;
        int due;
    } txn_t;

    txn_t q [$];
    int   hs_id [$];
    int   hs_sum [$];
    int   ptr_m, count_m, cyc;
    int   vectors, miscompares;
    bit   refill, rand_mode;
    bit   accepted [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge: outstanding results in a queue, winner chosen by the rotating search.
    task automatic observe();
        logic [NREQ-1:0] exp_ready;
        bit rv_exp, hs;
        int win, j;
        cyc++;
        for (int i = 0; i < NREQ; i++) accepted[i] = 1'b0;
        if (!rst_n) begin
            chk("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
            q.delete();
            ptr_m   = 0;
            count_m = 0;
            return;
        end
        rv_exp = (q.size() > 0) && (cyc >= q[0].due);
        hs     = rv_exp && rsp_ready_r;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv_exp));
        if (rv_exp) begin
            chk("rsp_id", 32'(bus.rsp_id), q[0].id);
            chk("rsp_sum", 32'(bus.rsp_sum), q[0].sum);
        end
        chk("op_count", 32'(op_count), count_m);
        chk("op_count_cntw4", 32'(op_count_s), (count_m > 15) ? 15 : count_m);
        win = -1;
        if ((q.size() == 0) || hs) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (ptr_m + k) % NREQ;
                if (win < 0 && req_valid_r[j]) win = j;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (hs) begin
            hs_id.push_back(q[0].id);
            hs_sum.push_back(q[0].sum);
            void'(q.pop_front());
            if (count_m < 65535) count_m++;
        end
        if (win >= 0) begin
            q.push_back('{win, int'(a_r[win]) + int'(b_r[win]), cyc + 2});
            ptr_m         = (win + 1) % NREQ;
            accepted[win] = 1'b1;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (accepted[i]) begin
                if (refill) begin
                    a_r[i] = 12'($urandom);
                    b_r[i] = 12'($urandom);
                end else begin
                    req_valid_r[i] = 1'b0;
                end
            end else if (rand_mode && !req_valid_r[i] && ($urandom_range(0, 2) == 0)) begin
                req_valid_r[i] = 1'b1;
                a_r[i] = 12'($urandom);
                b_r[i] = 12'($urandom);
            end
        end
        if (rand_mode) begin
            rsp_ready_r = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 59) != 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic chk_last(input string tag, input int exp_id, input int exp_sum);
        chk({tag, "_seen"}, 32'(hs_id.size() > 0), 32'd1);
        if (hs_id.size() > 0) begin
            chk({tag, "_id"}, hs_id[$], exp_id);
            chk({tag, "_sum"}, hs_sum[$], exp_sum);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; ptr_m = 0; count_m = 0;
        refill = 1'b0; rand_mode = 1'b0;
        rst_n = 1'b0; rsp_ready_r = 1'b1; req_valid_r = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = '0; b_r[i] = '0; accepted[i] = 1'b0;
        end

        steps(3);
        rst_n = 1'b1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        chk("reset_op_count",  32'(op_count),      32'd0);
        chk("reset_add_in",    32'(add_in),        32'd0);

        // Single request from requester 0
        a_r[0] = 12'h123; b_r[0] = 12'h456; req_valid_r[0] = 1'b1;
        steps(5);
        chk_last("single", 0, 'h579);
        chk("single_op_count", 32'(op_count), 32'd1);

        // Carry into bit W
        a_r[1] = 12'hFFF; b_r[1] = 12'h001; req_valid_r[1] = 1'b1;
        steps(4);
        chk_last("carry_1000", 1, 'h1000);
        a_r[2] = 12'hFFF; b_r[2] = 12'hFFF; req_valid_r[2] = 1'b1;
        steps(4);
        chk_last("carry_1ffe", 2, 'h1FFE);

        // Backpressure with a second request waiting
        rsp_ready_r = 1'b0;
        a_r[3] = 12'h7AA; b_r[3] = 12'h055; req_valid_r[3] = 1'b1;
        a_r[0] = 12'h010; b_r[0] = 12'h020; req_valid_r[0] = 1'b1;
        steps(7);
        chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
        chk("bp_rsp_sum_held", 32'(bus.rsp_sum), 32'h7FF);
        rsp_ready_r = 1'b1;
        steps(4);
        chk_last("bp_release", 0, 'h030);

        // Reset while the adder stage is busy
        a_r[2] = 12'h0AB; b_r[2] = 12'h0CD; req_valid_r[2] = 1'b1;
        step();
        rst_n = 1'b0; req_valid_r = '0;
        step();
        rst_n = 1'b1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_op_count",  32'(op_count),      32'd0);
        steps(3);

        // Fairness with every requester continuously pending
        hs_id.delete(); hs_sum.delete();
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = 12'($urandom); b_r[i] = 12'($urandom);
        end
        req_valid_r = '1;
        steps(14);
        chk("fair_count", 32'(hs_id.size() >= 6), 32'd1);
        if (hs_id.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk("fair_id", hs_id[k], k % NREQ);
        end
        refill = 1'b0;
        req_valid_r = '0;
        steps(4);

        // Random traffic with random backpressure and occasional resets
        rand_mode = 1'b1;
        steps(500);
        rand_mode = 1'b0;
        rst_n = 1'b1; rsp_ready_r = 1'b1; req_valid_r = '0;
        steps(6);

        // Saturation of the 4-bit counter, rebuilt from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        refill = 1'b1;
        req_valid_r = '1;
        steps(44);
        refill = 1'b0;
        req_valid_r = '0;
        steps(4);
        chk("sat_ops_done", 32'(count_m >= 20), 32'd1);
        chk("sat_hold", 32'(op_count_s), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
